io_state_bridge: RTL

//  Synthesizable, parametrised board-I/O bridge between a host/testbench and a DUT with SW/KEY/LED/HEX ports.

---
 rtl/io_state_bridge.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/io_state_bridge.sv
// Board-I/O bridge: applies SW/KEY vectors through a valid/ready handshake and logs
// timestamped LED/HEX changes in a first-word-fall-through event FIFO.
module io_state_bridge #(
  parameter int unsigned N_SW        = 10,
  parameter int unsigned N_KEY       = 4,
  parameter int unsigned N_LED       = 10,
  parameter int unsigned N_HEX       = 6,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TS_W        = 16,
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned SNAP_ON_UPD = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_SW+N_KEY-1:0]        in_data,
  output logic [N_SW-1:0]              SW,
  output logic [N_KEY-1:0]             KEY,
  input  logic [N_LED-1:0]             LED,
  input  logic [7*N_HEX-1:0]           HEX,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [N_LED+7*N_HEX-1:0]     ev_data,
  output logic [TS_W-1:0]              ev_ts,
  output logic                         overflow
);

  localparam int unsigned IN_W  = N_SW + N_KEY;
  localparam int unsigned OUT_W = N_LED + 7 * N_HEX;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SNAP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SET_W-1:0]   r_settle_cnt;
  logic [SET_W-1:0]   w_settle_cnt_nxt;
  logic               w_accept;
  logic               w_force;
  logic               r_in_ready;
  logic [N_SW-1:0]    r_sw;
  logic [N_KEY-1:0]   r_key;

  logic [TS_W-1:0]    r_ts;
  logic [OUT_W-1:0]   r_cur;
  logic [OUT_W-1:0]   r_prev;
  logic [TS_W-1:0]    r_cur_ts;
  logic               r_cur_ok;
  logic               r_prev_ok;
  logic               w_change;
  logic               w_push;

  logic [OUT_W-1:0]   r_mem_data [FIFO_DEPTH];
  logic [TS_W-1:0]    r_mem_ts   [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               r_ev_valid;
  logic               r_overflow;
  logic               w_pop;
  logic               w_full;
  logic               w_wr_en;

  // Handshake / settle sequencing
  always_comb begin
    w_state_nxt      = r_state;
    w_settle_cnt_nxt = r_settle_cnt;
    w_accept         = 1'b0;
    w_force          = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept         = 1'b1;
          w_settle_cnt_nxt = '0;
          w_state_nxt      = (SETTLE == 0) ? ST_SNAP : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_settle_cnt == SET_W'(SETTLE - 1)) begin
          w_state_nxt = ST_SNAP;
        end else begin
          w_settle_cnt_nxt = r_settle_cnt + SET_W'(1);
        end
      end
      ST_SNAP: begin
        w_force     = (SNAP_ON_UPD != 0);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_in_ready   <= 1'b1;
      r_sw         <= '0;
      r_key        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_in_ready   <= (w_state_nxt == ST_IDLE);
      if (w_accept) begin
        r_sw  <= in_data[N_SW-1:0];
        r_key <= in_data[IN_W-1:N_SW];
      end
    end
  end

  // Output sampling; cur/prev only compare once both hold post-reset samples
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ts      <= '0;
      r_cur     <= '0;
      r_prev    <= '0;
      r_cur_ts  <= '0;
      r_cur_ok  <= 1'b0;
      r_prev_ok <= 1'b0;
    end else begin
      r_ts      <= r_ts + TS_W'(1);
      r_cur     <= {HEX, LED};
      r_cur_ts  <= r_ts;
      r_prev    <= r_cur;
      r_cur_ok  <= 1'b1;
      r_prev_ok <= r_cur_ok;
    end
  end

  assign w_change = r_prev_ok & (r_cur != r_prev);
  assign w_push   = w_change | w_force;

  // Event FIFO
  assign w_pop   = r_ev_valid & ev_ready;
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_wr_en = w_push & (~w_full | w_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_en && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_wr_en && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ev_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_ev_valid <= (w_count_nxt != '0);
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_wr_en) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem_data[r_wr_ptr] <= r_cur;
      r_mem_ts[r_wr_ptr]   <= r_cur_ts;
    end
  end

  assign in_ready = r_in_ready;
  assign SW       = r_sw;
  assign KEY      = r_key;
  assign ev_valid = r_ev_valid;
  assign ev_data  = r_mem_data[r_rd_ptr];
  assign ev_ts    = r_mem_ts[r_rd_ptr];
  assign overflow = r_overflow;

endmodule
